// File: rtl/cosine_pkg.sv
// Shared types and widths for the cosine controller and its datapath.
package cosine_pkg;

    localparam int unsigned DataWidth    = 16;
    localparam int unsigned TermIdxWidth = 4;
    localparam int unsigned HoldWidth    = 8;

    // Control code seen by the datapath; codes 5-7 are never produced.
    typedef enum logic [2:0] {
        StStandby    = 3'd0,
        StAlert      = 3'd1,
        StStartCalc  = 3'd2,
        StAccumulate = 3'd3,
        StCalcDist   = 3'd4
    } stateE;

endpackage

// File: rtl/cosine_controller_cycle_counter.sv
// Up-counter with clear-on-load and a terminal-count flag at count == limit.
module cycle_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [Width-1:0] limit,
    output logic [Width-1:0] count,
    output logic             tc
);

    // Load returns the count to zero; it wins over enable.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + Width'(1);
        end
    end

    // Flag only while counting, so an idle counter never signals completion.
    always_comb begin
        tc = enable && (count == limit);
    end

endmodule

// File: rtl/cosine_controller.sv
// Sequencer for one cosine-distance calculation: start, term accumulation,
// wait for the datapath, optional alert hold.
// Optional feature: define COSINE_WATCHDOG_EN to bound the datapath wait and
// add the timeout_err output.
module cosine_controller
    import cosine_pkg::*;
#(
    parameter int unsigned NUM_TERMS  = 6,
    parameter int unsigned ALERT_HOLD = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    dp_done,
    input  logic [DataWidth-1:0]    distance,
    input  logic [DataWidth-1:0]    alarm_limit,
    output logic [2:0]              state,
    output logic [TermIdxWidth-1:0] term_index,
    output logic                    busy,
    output logic                    alert,
    output logic [DataWidth-1:0]    result,
    output logic                    result_valid
`ifdef COSINE_WATCHDOG_EN
    ,
    output logic                    timeout_err
`endif
);

    stateE                 stateQ;
    logic                  inAccumulate;
    logic                  inAlert;
    logic                  inCalc;
    logic                  termTc;
    logic                  holdEn;
    logic                  holdLoad;
    logic                  holdTc;
    logic [HoldWidth-1:0]  holdLimit;
    logic [HoldWidth-1:0]  holdCount;

    assign state        = stateQ;
    assign inAccumulate = (stateQ == StAccumulate);
    assign inAlert      = (stateQ == StAlert);
    assign inCalc       = (stateQ == StCalcDist);

    // Term counter is held at zero outside accumulation and clears itself on
    // the last term, so term_index reads 0 in every other state.
    cycle_counter #(
        .Width (TermIdxWidth)
    ) u_termCounter (
        .clk    (clk),
        .rst    (rst),
        .load   (!inAccumulate || termTc),
        .enable (inAccumulate),
        .limit  (TermIdxWidth'(NUM_TERMS - 1)),
        .count  (term_index),
        .tc     (termTc)
    );

    // One counter serves both the alert hold and the datapath watchdog;
    // the limit follows whichever state is active.
    always_comb begin
`ifdef COSINE_WATCHDOG_EN
        holdEn = inAlert || inCalc;
`else
        holdEn = inAlert;
`endif
        holdLimit = inAlert ? HoldWidth'(ALERT_HOLD - 1) : HoldWidth'(TIMEOUT - 1);
        // Clear on leaving CALCULATE_DISTANCE so ALERT starts its hold at 0.
        holdLoad  = !holdEn || holdTc || (inCalc && dp_done) || (holdCount == '1 && !holdTc);
    end

    cycle_counter #(
        .Width (HoldWidth)
    ) u_holdCounter (
        .clk    (clk),
        .rst    (rst),
        .load   (holdLoad),
        .enable (holdEn),
        .limit  (holdLimit),
        .count  (holdCount),
        .tc     (holdTc)
    );

    // State register with registered status outputs and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ       <= StStandby;
            busy         <= 1'b0;
            alert        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef COSINE_WATCHDOG_EN
            timeout_err  <= 1'b0;
`endif
        end else begin
            result_valid <= 1'b0;
`ifdef COSINE_WATCHDOG_EN
            timeout_err  <= 1'b0;
`endif
            case (stateQ)
                StStandby: begin
                    if (start) begin
                        stateQ <= StStartCalc;
                        busy   <= 1'b1;
                    end
                end
                StStartCalc: begin
                    stateQ <= StAccumulate;
                end
                StAccumulate: begin
                    if (termTc) begin
                        stateQ <= StCalcDist;
                    end
                end
                StCalcDist: begin
                    // Completion wins over a watchdog expiry on the same cycle.
                    if (dp_done) begin
                        result       <= distance;
                        result_valid <= 1'b1;
                        if (distance > alarm_limit) begin
                            stateQ <= StAlert;
                            alert  <= 1'b1;
                        end else begin
                            stateQ <= StStandby;
                            busy   <= 1'b0;
                        end
                    end
`ifdef COSINE_WATCHDOG_EN
                    else if (holdTc) begin
                        stateQ      <= StStandby;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
`endif
                end
                StAlert: begin
                    if (holdTc) begin
                        stateQ <= StStandby;
                        busy   <= 1'b0;
                        alert  <= 1'b0;
                    end
                end
                default: begin
                    stateQ <= StStandby;
                    busy   <= 1'b0;
                    alert  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cosine_controller.sv
// Directed bench for cosine_controller at default parameters.
module tb_cosine_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dp_done;
    logic [15:0] distance;
    logic [15:0] alarm_limit;
    logic [2:0]  state;
    logic [3:0]  term_index;
    logic        busy;
    logic        alert;
    logic [15:0] result;
    logic        result_valid;
`ifdef COSINE_WATCHDOG_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    cosine_controller dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dp_done      (dp_done),
        .distance     (distance),
        .alarm_limit  (alarm_limit),
        .state        (state),
        .term_index   (term_index),
        .busy         (busy),
        .alert        (alert),
        .result       (result),
        .result_valid (result_valid)
`ifdef COSINE_WATCHDOG_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // From STANDBY at cycle 0: pulse start, walk through cycles 1-8.
    task automatic runToCalc(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ":startState"}, 16'(state), 16'd2);
        chk({tag, ":startBusy"}, 16'(busy), 16'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk({tag, ":accState"}, 16'(state), 16'd3);
            chk({tag, ":termIdx"}, 16'(term_index), 16'(i));
        end
        tick();
        chk({tag, ":calcState"}, 16'(state), 16'd4);
        chk({tag, ":calcTerm"}, 16'(term_index), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dp_done = 1'b0;
        distance = '0;
        alarm_limit = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rstState", 16'(state), 16'd0);
        chk("rstTerm", 16'(term_index), 16'd0);
        chk("rstBusy", 16'(busy), 16'd0);
        chk("rstAlert", 16'(alert), 16'd0);
        chk("rstResult", result, 16'd0);
        chk("rstValid", 16'(result_valid), 16'd0);

        // dp_done in STANDBY is ignored.
        dp_done = 1'b1;
        distance = 16'd77;
        tick();
        dp_done = 1'b0;
        chk("idleState", 16'(state), 16'd0);
        chk("idleValid", 16'(result_valid), 16'd0);
        chk("idleResult", result, 16'd0);

        // Below threshold: 100 vs 200.
        runToCalc("below");
        dp_done = 1'b1;
        distance = 16'd100;
        alarm_limit = 16'd200;
        tick();
        dp_done = 1'b0;
        chk("belowState", 16'(state), 16'd0);
        chk("belowResult", result, 16'd100);
        chk("belowValid", 16'(result_valid), 16'd1);
        chk("belowAlert", 16'(alert), 16'd0);
        chk("belowBusy", 16'(busy), 16'd0);
        tick();
        chk("belowValidOff", 16'(result_valid), 16'd0);
        chk("belowHold", result, 16'd100);

        // Above threshold: alert for cycles 9-12, STANDBY at 13.
        runToCalc("above");
        dp_done = 1'b1;
        distance = 16'd300;
        tick();
        dp_done = 1'b0;
        chk("aboveValid", 16'(result_valid), 16'd1);
        chk("aboveResult", result, 16'd300);
        for (int i = 0; i < 4; i++) begin
            chk("alertState", 16'(state), 16'd1);
            chk("alertHigh", 16'(alert), 16'd1);
            chk("alertBusy", 16'(busy), 16'd1);
            tick();
        end
        chk("alertExit", 16'(state), 16'd0);
        chk("alertLow", 16'(alert), 16'd0);
        chk("alertBusyLow", 16'(busy), 16'd0);

        // Equal: no alert.
        runToCalc("equal");
        dp_done = 1'b1;
        distance = 16'd200;
        tick();
        dp_done = 1'b0;
        chk("equalState", 16'(state), 16'd0);
        chk("equalAlert", 16'(alert), 16'd0);
        chk("equalResult", result, 16'd200);

        // Held start: re-trigger on the first STANDBY cycle.
        start = 1'b1;
        tick();
        chk("heldStart", 16'(state), 16'd2);
        for (int i = 0; i < 6; i++) tick();
        chk("heldAccDone", 16'(term_index), 16'd5);
        tick();
        chk("heldCalc", 16'(state), 16'd4);
        dp_done = 1'b1;
        distance = 16'd5;
        tick();
        chk("heldStandby", 16'(state), 16'd0);
        chk("heldValid", 16'(result_valid), 16'd1);
        tick();
        chk("heldRetrig", 16'(state), 16'd2);
        chk("heldBusy", 16'(busy), 16'd1);
        // dp_done still high outside CALCULATE_DISTANCE: ignored.
        chk("heldNoValid", 16'(result_valid), 16'd0);
        start = 1'b0;
        dp_done = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("heldCalc2", 16'(state), 16'd4);
        dp_done = 1'b1;
        distance = 16'd9;
        tick();
        dp_done = 1'b0;
        chk("heldResult2", result, 16'd9);
        chk("heldEnd", 16'(state), 16'd0);

        // Reset mid-accumulation (cycle 5, term 3); rst beats start.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midTerm", 16'(term_index), 16'd3);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("midRstState", 16'(state), 16'd0);
        chk("midRstTerm", 16'(term_index), 16'd0);
        chk("midRstBusy", 16'(busy), 16'd0);
        chk("midRstResult", result, 16'd0);
        chk("midRstValid", 16'(result_valid), 16'd0);
        chk("midRstAlert", 16'(alert), 16'd0);

`ifdef COSINE_WATCHDOG_EN
        // Seed a result, then let the watchdog expire.
        runToCalc("wdSeed");
        dp_done = 1'b1;
        distance = 16'd42;
        tick();
        dp_done = 1'b0;
        runToCalc("wd");
        begin
            int waited = 0;
            while (timeout_err !== 1'b1 && waited < 200) begin
                tick();
                waited++;
            end
            chk("wdCycles", 16'(waited), 16'd64);
        end
        chk("wdState", 16'(state), 16'd0);
        chk("wdResult", result, 16'd42);
        tick();
        chk("wdPulse", 16'(timeout_err), 16'd0);
`else
        // Without the watchdog the wait is unbounded.
        runToCalc("noWd");
        for (int i = 0; i < 100; i++) tick();
        chk("noWdState", 16'(state), 16'd4);
        chk("noWdBusy", 16'(busy), 16'd1);
        dp_done = 1'b1;
        distance = 16'd1;
        tick();
        dp_done = 1'b0;
        chk("noWdDone", 16'(state), 16'd0);
        chk("noWdResult", result, 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
